// File: rtl/duty_meas_multi_if.sv
// duty_meas_multi_if
//   Bundles the measurement controls, the PWM inputs and the per-channel
//   results of duty_meas_multi.
//   master : drives en, clr_stats, pwm; observes the results
//   slave  : the monitor itself
// Signals
//   en         measurement enable
//   clr_stats  1-cycle pulse, restarts the min/max trackers
//   pwm        PWM inputs, bit i = channel i
//   duty       last-window duty, channel i = [i*WIDTH +: WIDTH]
//   duty_min   lowest duty since reset/clr_stats
//   duty_max   highest duty since reset/clr_stats
//   stuck_hi   last window had no edge and pwm was high throughout
//   stuck_lo   last window had no edge and pwm was low throughout
//   vld        1-clk pulse when the result signals update
interface duty_meas_multi_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8
);
    logic                    en;
    logic                    clr_stats;
    logic [NUM_CH-1:0]       pwm;
    logic [NUM_CH*WIDTH-1:0] duty;
    logic [NUM_CH*WIDTH-1:0] duty_min;
    logic [NUM_CH*WIDTH-1:0] duty_max;
    logic [NUM_CH-1:0]       stuck_hi;
    logic [NUM_CH-1:0]       stuck_lo;
    logic                    vld;

    modport master (
        output en, clr_stats, pwm,
        input  duty, duty_min, duty_max, stuck_hi, stuck_lo, vld
    );

    modport slave (
        input  en, clr_stats, pwm,
        output duty, duty_min, duty_max, stuck_hi, stuck_lo, vld
    );
endinterface

// File: rtl/duty_meas_multi.sv
// duty_meas_multi
//   N-channel PWM duty-cycle monitor. Each channel is sampled over a fixed
//   2^WIN_LOG2-clock window (clocks with en=1); at the end of the window the
//   high count is scaled to a WIDTH-bit duty (all-ones = 100%), min/max are
//   tracked and stuck-high/stuck-low flags are raised for edge-free windows.
// Parameters
//   NUM_CH    number of channels
//   WIDTH     duty result width (WIN_LOG2 >= WIDTH)
//   WIN_LOG2  log2 of the window length in clocks
//   SYNC      0 = pwm used directly, 2 = two-flop synchronizer per channel
// Ports
//   clk    system clock, posedge
//   rst_n  synchronous active-low reset
//   bus    duty_meas_multi_if slave modport (controls, pwm, results)

// Per-channel counter, edge detector and result registers.
module duty_meas_ch #(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             first,     // shared window counter is at 0
    input  logic             last,      // shared window counter is at its max
    input  logic             clr_stats,
    input  logic             pwm_s,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] duty_min,
    output logic [WIDTH-1:0] duty_max,
    output logic             stuck_hi,
    output logic             stuck_lo
);
    localparam int SHIFT = WIN_LOG2 - WIDTH;

    logic [WIN_LOG2:0] hi_cnt;
    logic [WIN_LOG2:0] tot;
    logic [WIN_LOG2:0] tot_sh;
    logic [WIDTH-1:0]  d_new;
    logic              edge_flg;
    logic              edge_now;
    logic              edge_any;
    logic              pwm_prev;
    logic              win_end;

    // tot includes the current sample so the final cycle of a window counts.
    assign tot      = hi_cnt + {{WIN_LOG2{1'b0}}, pwm_s};
    assign tot_sh   = tot >> SHIFT;
    // Only an all-high window overflows WIDTH bits; clamp it to 100%.
    assign d_new    = (|tot_sh[WIN_LOG2:WIDTH]) ? '1 : tot_sh[WIDTH-1:0];
    // pwm_prev on the first window cycle belongs to the previous window.
    assign edge_now = !first && (pwm_s != pwm_prev);
    assign edge_any = edge_flg | edge_now;
    assign win_end  = en && last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_cnt   <= '0;
            edge_flg <= 1'b0;
            pwm_prev <= 1'b0;
            duty     <= '0;
            duty_min <= '1;
            duty_max <= '0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
        end else begin
            pwm_prev <= pwm_s;

            if (!en || last) begin
                hi_cnt   <= '0;
                edge_flg <= 1'b0;
            end else begin
                hi_cnt   <= tot;
                edge_flg <= edge_any;
            end

            if (win_end) begin
                duty     <= d_new;
                stuck_hi <= !edge_any && (tot == {1'b1, {WIN_LOG2{1'b0}}});
                stuck_lo <= !edge_any && (tot == '0);
                // A clear coinciding with the window end restarts the
                // trackers from the new sample.
                duty_min <= (clr_stats || d_new < duty_min) ? d_new : duty_min;
                duty_max <= (clr_stats || d_new > duty_max) ? d_new : duty_max;
            end else if (clr_stats) begin
                duty_min <= '1;
                duty_max <= '0;
            end
        end
    end
endmodule

module duty_meas_multi #(
    parameter int NUM_CH   = 3,
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 12,
    parameter int SYNC     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    duty_meas_multi_if.slave bus
);
    logic [NUM_CH-1:0]             pwm_s;
    logic [WIN_LOG2-1:0]           win_cnt;
    logic                          vld_r;
    logic [NUM_CH-1:0][WIDTH-1:0]  duty_a;
    logic [NUM_CH-1:0][WIDTH-1:0]  min_a;
    logic [NUM_CH-1:0][WIDTH-1:0]  max_a;
    logic [NUM_CH-1:0]             shi_a;
    logic [NUM_CH-1:0]             slo_a;
    logic                          first;
    logic                          last;

    if (SYNC == 2) begin : g_sync
        logic [NUM_CH-1:0] s1;
        logic [NUM_CH-1:0] s2;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1 <= '0;
                s2 <= '0;
            end else begin
                s1 <= bus.pwm;
                s2 <= s1;
            end
        end
        assign pwm_s = s2;
    end else begin : g_nosync
        assign pwm_s = bus.pwm;
    end

    assign first = (win_cnt == '0);
    assign last  = (win_cnt == '1);

    // Shared window counter; en=0 discards the partial window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt <= '0;
            vld_r   <= 1'b0;
        end else begin
            vld_r   <= bus.en && last;
            win_cnt <= bus.en ? win_cnt + 1'b1 : '0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        duty_meas_ch #(
            .WIDTH    (WIDTH),
            .WIN_LOG2 (WIN_LOG2)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (bus.en),
            .first     (first),
            .last      (last),
            .clr_stats (bus.clr_stats),
            .pwm_s     (pwm_s[i]),
            .duty      (duty_a[i]),
            .duty_min  (min_a[i]),
            .duty_max  (max_a[i]),
            .stuck_hi  (shi_a[i]),
            .stuck_lo  (slo_a[i])
        );
    end

    assign bus.duty     = duty_a;
    assign bus.duty_min = min_a;
    assign bus.duty_max = max_a;
    assign bus.stuck_hi = shi_a;
    assign bus.stuck_lo = slo_a;
    assign bus.vld      = vld_r;
endmodule
